// File: rtl/alu_serial.sv
// Nibble-serial ALU: operands latched on start, one 4-bit digit per cycle,
// LSB digit first, with a registered carry/borrow chain and packed-BCD add/sub.
module alu_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             c_in,
  input  logic             bcd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_EOR  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_DEC  = 4'h6;
  localparam logic [3:0] OP_ASL  = 4'h7;
  localparam logic [3:0] OP_ROL  = 4'h8;
  localparam logic [3:0] OP_ROR  = 4'h9;
  localparam logic [3:0] OP_TEST = 4'ha;
  localparam logic [3:0] OP_ONES = 4'hb;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, y_sh;
  logic [3:0]       op_q;
  logic             cin_q, bcd_q, carry;

  logic [WIDTH+1:0] a_ext;
  logic [CW+1:0]    base;
  logic [5:0]       win;
  logic [3:0]       a_d, b_d, res;
  logic [4:0]       sum;
  logic             last, lo_nb, hi_nb, carry_nxt;
  logic [WIDTH-1:0] y_fin;
  logic             cout_fin, neg_fin, ov_fin;

  // Current digit result, next carry and the completed result/flags.
  always_comb begin
    a_ext     = {1'b0, a_q, 1'b0};
    base      = {cnt, 2'b00};
    win       = a_ext[base +: 6];
    a_d       = win[4:1];
    b_d       = b_q[base +: 4];
    last      = (cnt == CW'(N - 1));
    lo_nb     = (cnt == '0) ? ((op_q == OP_ROL) ? cin_q : 1'b0) : win[0];
    hi_nb     = last ? cin_q : win[5];
    sum       = 5'd0;
    res       = 4'd0;
    carry_nxt = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum = {1'b0, b_d} + {1'b0, a_d} + 5'(carry);
        if (bcd_q && (sum > 5'd9)) begin
          res       = sum[3:0] + 4'd6;
          carry_nxt = 1'b1;
        end else begin
          res       = sum[3:0];
          carry_nxt = sum[4];
        end
      end
      OP_SUB: begin
        sum       = {1'b0, b_d} - {1'b0, a_d} - 5'(carry);
        carry_nxt = sum[4];
        res       = (bcd_q && sum[4]) ? (sum[3:0] - 4'd6) : sum[3:0];
      end
      OP_OR:   res = a_d | b_d;
      OP_AND:  res = a_d & b_d;
      OP_EOR:  res = a_d ^ b_d;
      OP_TEST: res = a_d & b_d;
      OP_INC: begin
        sum       = {1'b0, a_d} + 5'(carry);
        res       = sum[3:0];
        carry_nxt = sum[4];
      end
      OP_DEC: begin
        sum       = {1'b0, a_d} - 5'(carry);
        res       = sum[3:0];
        carry_nxt = sum[4];
      end
      OP_ASL, OP_ROL: res = {a_d[2:0], lo_nb};
      OP_ROR:         res = {hi_nb, a_d[3:1]};
      OP_ONES:        res = 4'hf;
      default:        res = 4'h0;
    endcase

    y_fin             = y_sh;
    y_fin[base +: 4]  = res;

    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: cout_fin = carry_nxt;
      OP_ASL, OP_ROL:                 cout_fin = a_q[WIDTH-1];
      OP_ROR:                         cout_fin = a_q[0];
      OP_ONES:                        cout_fin = 1'b1;
      default:                        cout_fin = 1'b0;
    endcase

    neg_fin = (op_q == OP_TEST) ? a_q[WIDTH-1] : y_fin[WIDTH-1];

    case (op_q)
      OP_ADD:         ov_fin = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                               (y_fin[WIDTH-1] != a_q[WIDTH-1]);
      OP_SUB, OP_DEC: ov_fin = (b_q[WIDTH-1] != a_q[WIDTH-1]) &&
                               (y_fin[WIDTH-1] != b_q[WIDTH-1]);
      OP_TEST:        ov_fin = a_q[WIDTH-2];
      default:        ov_fin = 1'b0;
    endcase
  end

  // Control FSM, operand latches, digit chain and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      y_sh     <= '0;
      op_q     <= 4'h0;
      cin_q    <= 1'b0;
      bcd_q    <= 1'b0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= '0;
      c_out    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cin_q <= c_in;
            bcd_q <= bcd;
            carry <= c_in;
            cnt   <= '0;
            y_sh  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          y_sh  <= y_fin;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            y        <= y_fin;
            c_out    <= cout_fin;
            zero     <= (y_fin == '0);
            negative <= neg_fin;
            overflow <= ov_fin;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
